gcd_dispatcher: RTL and testbench
=================================

GCD_DISPATCHER -- requirements
Module: gcd_dispatcher

Interface
REQ-001 Parameter: DEPTH, 4, operand FIFO entries (power of two, 2..16).
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst  in  1  synchronous active-high reset.
REQ-004 Port: in_valid  in  1  operand pair offered.
REQ-005 Port: in_a, in_b  in  16 each  operand pair.
REQ-006 Port: in_ready  out  1  FIFO can accept a pair.
REQ-007 Port: gcd_start  out  1  one-cycle start pulse to the GCD core.
REQ-008 Port: gcd_a, gcd_b  out  16 each  operands to the GCD core.
REQ-009 Port: gcd_done  in  1  GCD core done, high for 2 cycles per job.
REQ-010 Port: gcd_result  in  16  GCD core result, valid while gcd_done is high.
REQ-011 Port: out_valid  out  1  result available.
REQ-012 Port: out_gcd, out_a, out_b  out  16 each  result and echoed operands.
REQ-013 Port: out_ready  in  1  consumer accepts the result.

Function
REQ-014 The FIFO SHALL push on the rising edge of any cycle with in_valid && in_ready; in_ready = (count != DEPTH), derived from registered count only.
REQ-015 FSM states SHALL be IDLE, ISSUE, BUSY, RESP.
REQ-016 IDLE->ISSUE SHALL occur when count != 0 and gcd_done == 0; on that edge the head pair loads into gcd_a/gcd_b and the FIFO pops.
REQ-017 ISSUE SHALL last exactly one cycle with gcd_start = 1, then go to BUSY; gcd_start SHALL be 0 in all other states.
REQ-018 gcd_a/gcd_b SHALL hold stable from ISSUE until the next IDLE->ISSUE load.
REQ-019 BUSY->RESP SHALL occur on the first cycle gcd_done == 1; on that edge gcd_result -> out_gcd and gcd_a/gcd_b -> out_a/out_b are captured; the second done cycle SHALL be ignored.
REQ-020 In RESP, out_valid = 1; out_* SHALL stay stable until a cycle with out_ready == 1, after which the FSM goes to IDLE.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-022 A push attempted when full SHALL be dropped; FIFO contents SHALL be unchanged.
REQ-023 gcd_done seen in IDLE, ISSUE or RESP SHALL be ignored, and no start SHALL issue while gcd_done == 1.
REQ-024 Zero operands SHALL pass through unmodified: (0,0) -> 0 and (0,x) -> x, exactly as the core reports.
REQ-025 Minimum latency from in_valid accepted (empty FIFO, IDLE) to gcd_start SHALL be 2 cycles, and from first gcd_done to out_valid 1 cycle.

Reset
REQ-026 rst SHALL set state IDLE, FIFO pointers and count 0, and gcd_start, out_valid, gcd_a, gcd_b, out_gcd, out_a, out_b all 0; in_ready = 1 in the cycle after reset.
REQ-027 rst asserted in BUSY or RESP SHALL abandon the job with no out_valid; the top level drives the core's rst_n = ~rst.

Configuration
REQ-028 With GCD_JOB_COUNT_EN defined, output job_cnt[15:0] SHALL exist, increment on each RESP handshake, saturate at 16'hFFFF, and reset to 0.
REQ-029 Without GCD_JOB_COUNT_EN, job_cnt and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification (bench instantiates the real GCD core)
REQ-030 Push (48,18), out_ready = 1 -> gcd_start 2 cycles after push; out_valid with out_gcd = 6, out_a = 48, out_b = 18.
REQ-031 Push (0,0), (0,7), (9,0) back-to-back -> results 0, 7, 9 in order, each delivered exactly once.
REQ-032 out_ready = 0, push 5 pairs while the first is computing -> in_ready = 0 at count = 4 and the 5th pair is dropped; out_* stay stable; no gcd_start while in RESP.
REQ-033 rst pulse while BUSY on (65535,1) -> no out_valid; FIFO empty; next push (12,8) yields 4.
REQ-034 Random 200 pairs with random out_ready -> each out_gcd matches a reference GCD, in order; gcd_start never high while gcd_done is high.
REQ-035 GCD_JOB_COUNT_EN defined, 3 jobs completed -> job_cnt = 3; preload 16'hFFFF and complete 1 job -> job_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/gcd_dispatcher.sv
// gcd_dispatcher: operand FIFO in front of an external multi-cycle GCD core.
// Pairs are queued, issued one at a time with a single-cycle start pulse, and
// the core's result is held with the echoed operands until the consumer takes it.
// The core is expected to be reset with rst_n = ~rst at the level above.
// Optional feature: define GCD_JOB_COUNT_EN to add the saturating job_cnt output.
module gcd_dispatcher #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        in_ready,
  output logic        gcd_start,
  output logic [15:0] gcd_a,
  output logic [15:0] gcd_b,
  input  logic        gcd_done,
  input  logic [15:0] gcd_result,
  output logic        out_valid,
  output logic [15:0] out_gcd,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  input  logic        out_ready
`ifdef GCD_JOB_COUNT_EN
  ,
  output logic [15:0] job_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          capture;
  logic          resp_hs;

  // Full flag comes from the registered count only, so in_ready never depends on in_valid.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // A new job only starts from IDLE, with data queued and the core not signalling done.
  assign pop      = (state == IDLE) && (count != '0) && !gcd_done;
  // Only the first done cycle seen in BUSY carries the result we keep.
  assign capture  = (state == BUSY) && gcd_done;
  assign resp_hs  = (state == RESP) && out_ready;

  // FIFO storage write.
  // NOTE: storage arrays carry no reset; count and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pop)       state_nxt = ISSUE;
      ISSUE:                  state_nxt = BUSY;
      BUSY:    if (gcd_done)  state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // FSM outputs: start pulse in ISSUE only, result valid throughout RESP.
  always_comb begin
    gcd_start = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ISSUE:   gcd_start = 1'b1;
      RESP:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand and result registers: operands load on the IDLE->ISSUE edge and hold until
  // the next load; the result and echoed operands load on the first done cycle in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      gcd_a   <= '0;
      gcd_b   <= '0;
      out_gcd <= '0;
      out_a   <= '0;
      out_b   <= '0;
    end else begin
      if (pop) begin
        {gcd_a, gcd_b} <= mem[rd_ptr];
      end
      if (capture) begin
        out_gcd <= gcd_result;
        out_a   <= gcd_a;
        out_b   <= gcd_b;
      end
    end
  end

`ifdef GCD_JOB_COUNT_EN
  // Completed-job counter: one count per accepted result, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_cnt <= '0;
    end else if (resp_hs && (job_cnt != 16'hFFFF)) begin
      job_cnt <= job_cnt + 16'd1;
    end
  end
`else
  // resp_hs only feeds the job counter; keep it referenced when the counter is absent.
  logic unused_resp_hs;
  assign unused_resp_hs = resp_hs;
`endif

endmodule

// File: tb/tb_gcd_dispatcher.sv
// Testbench for gcd_dispatcher with a behavioural GCD core (reset by rst_n = ~rst).
// Expected results are queued when a pair is accepted and compared on each handshake.
module tb_gcd_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_ready;
  logic        gcd_start;
  logic [15:0] gcd_a;
  logic [15:0] gcd_b;
  logic        gcd_done;
  logic [15:0] gcd_result;
  logic        out_valid;
  logic [15:0] out_gcd;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        out_ready;
`ifdef GCD_JOB_COUNT_EN
  logic [15:0] job_cnt;
`endif

  always #5 clk = ~clk;

  gcd_dispatcher #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ready   (in_ready),
    .gcd_start  (gcd_start),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .out_valid  (out_valid),
    .out_gcd    (out_gcd),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_ready  (out_ready)
`ifdef GCD_JOB_COUNT_EN
    ,
    .job_cnt    (job_cnt)
`endif
  );

  int n_checks    = 0;
  int n_fail      = 0;
  int n_delivered = 0;

  typedef struct packed {
    logic [15:0] g;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  bit rand_ready = 1'b0;
  int force_lat  = -1;
  bit spur_done  = 1'b0;

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural GCD core: latches operands on start, waits a few cycles,
  // then raises done for exactly two cycles with the result.
  logic        core_rst_n;
  logic        core_done;
  logic        core_busy;
  logic        core_tail;
  int          core_wait;
  logic [15:0] core_a;
  logic [15:0] core_b;

  assign core_rst_n = ~rst;
  assign gcd_done   = core_done | spur_done;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_done  <= 1'b0;
      core_busy  <= 1'b0;
      core_tail  <= 1'b0;
      core_wait  <= 0;
      gcd_result <= 16'hBEEF;
    end else if (core_done) begin
      if (core_tail) begin
        core_tail <= 1'b0;
      end else begin
        core_done  <= 1'b0;
        gcd_result <= 16'hBEEF;
      end
    end else if (core_busy) begin
      if (core_wait > 0) begin
        core_wait <= core_wait - 1;
      end else begin
        core_done  <= 1'b1;
        core_tail  <= 1'b1;
        core_busy  <= 1'b0;
        gcd_result <= ref_gcd(core_a, core_b);
      end
    end else if (gcd_start) begin
      core_busy <= 1'b1;
      core_a    <= gcd_a;
      core_b    <= gcd_b;
      core_wait <= (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
    end
  end

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("start_while_done", 32'(gcd_start && gcd_done), 32'd0);
      if (out_valid && out_ready) begin
        check("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_gcd", out_gcd, mon_e.g);
          check("out_a",   out_a,   mon_e.a);
          check("out_b",   out_b,   mon_e.b);
          n_delivered++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one pair for one cycle; queue its result if it was accepted.
  task automatic push_pair(input logic [15:0] a, input logic [15:0] b, output bit accepted);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    accepted = in_ready;
    if (in_ready) exp_q.push_back('{g: ref_gcd(a, b), a: a, b: b});
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_retry(input logic [15:0] a, input logic [15:0] b);
    bit ok;
    int tries;
    ok    = 1'b0;
    tries = 0;
    while (!ok && tries < 200) begin
      push_pair(a, b, ok);
      tries++;
    end
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (gcd_start) break;
      n++;
    end
    check("start_seen", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    check("valid_seen", 32'(n < budget), 32'd1);
  endtask

  initial begin
    bit ok;
    int d0;
    int n;
    logic [15:0] ra;
    logic [15:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset values.
    repeat (3) step();
    @(negedge clk);
    check("rst_gcd_start", 32'(gcd_start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_gcd_a",     gcd_a,   16'd0);
    check("rst_gcd_b",     gcd_b,   16'd0);
    check("rst_out_gcd",   out_gcd, 16'd0);
    check("rst_out_a",     out_a,   16'd0);
    check("rst_out_b",     out_b,   16'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    step();

    // (48,18): start two cycles after the offer, result one cycle after done.
    out_ready = 1'b1;
    force_lat = 2;
    push_pair(16'd48, 16'd18, ok);
    check("t1_accept", 32'(ok), 32'd1);
    @(negedge clk);
    check("t1_start_cycle1", 32'(gcd_start), 32'd0);
    step();
    @(negedge clk);
    check("t1_start_cycle2", 32'(gcd_start), 32'd1);
    check("t1_gcd_a", gcd_a, 16'd48);
    check("t1_gcd_b", gcd_b, 16'd18);
    n = 0;
    while (!gcd_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_done_seen", 32'(n < 20), 32'd1);
    check("t1_valid_at_done", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_after_done", 32'(out_valid), 32'd1);
    check("t1_out_gcd", out_gcd, 16'd6);
    check("t1_out_a",   out_a,   16'd48);
    check("t1_out_b",   out_b,   16'd18);
    step();
    wait_drain(50);

    // Done asserted while IDLE with a queued pair: no start, no result.
    force_lat = -1;
    spur_done = 1'b1;
    push_pair(16'd30, 16'd12, ok);
    check("t2s_accept", 32'(ok), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("t2s_no_start", 32'(gcd_start), 32'd0);
      check("t2s_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    spur_done = 1'b0;
    wait_start(10);
    step();
    wait_drain(100);

    // Zero operands pass through, in order, each delivered once.
    d0 = n_delivered;
    push_pair(16'd0, 16'd0, ok);
    check("t2_accept0", 32'(ok), 32'd1);
    push_pair(16'd0, 16'd7, ok);
    check("t2_accept1", 32'(ok), 32'd1);
    push_pair(16'd9, 16'd0, ok);
    check("t2_accept2", 32'(ok), 32'd1);
    wait_drain(200);
    check("t2_delivered", 32'(n_delivered - d0), 32'd3);
    repeat (5) step();
    @(negedge clk);
    check("t2_idle_valid", 32'(out_valid), 32'd0);
    step();

    // Back-pressure: fill the FIFO while the first job is in flight; fifth extra pair dropped.
    out_ready = 1'b0;
    force_lat = 3;
    push_pair(16'd100, 16'd75, ok);
    check("t3_accept_p0", 32'(ok), 32'd1);
    wait_start(10);
    step();
    push_pair(16'd84, 16'd36, ok);
    check("t3_accept_p1", 32'(ok), 32'd1);
    push_pair(16'd21, 16'd14, ok);
    check("t3_accept_p2", 32'(ok), 32'd1);
    push_pair(16'd17, 16'd5, ok);
    check("t3_accept_p3", 32'(ok), 32'd1);
    push_pair(16'd1000, 16'd250, ok);
    check("t3_accept_p4", 32'(ok), 32'd1);
    @(negedge clk);
    check("t3_full_in_ready", 32'(in_ready), 32'd0);
    push_pair(16'd7, 16'd49, ok);
    check("t3_dropped_p5", 32'(ok), 32'd0);
    wait_valid(30);
    repeat (8) begin
      @(negedge clk);
      check("t3_hold_valid",   32'(out_valid), 32'd1);
      check("t3_hold_gcd",     out_gcd, 16'd25);
      check("t3_hold_a",       out_a,   16'd100);
      check("t3_hold_b",       out_b,   16'd75);
      check("t3_no_start_resp", 32'(gcd_start), 32'd0);
      step();
    end
    out_ready = 1'b1;
    force_lat = -1;
    wait_drain(200);
    @(negedge clk);
    check("t3_in_ready_after", 32'(in_ready), 32'd1);
    step();

    // Reset while BUSY abandons the job; FIFO is empty afterwards.
    force_lat = 6;
    push_pair(16'd65535, 16'd1, ok);
    check("t4_accept", 32'(ok), 32'd1);
    wait_start(10);
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("t4_no_valid", 32'(out_valid), 32'd0);
      check("t4_no_start", 32'(gcd_start), 32'd0);
      check("t4_in_ready", 32'(in_ready),  32'd1);
      step();
    end
    force_lat = -1;
    d0 = n_delivered;
    push_pair(16'd12, 16'd8, ok);
    check("t4_accept_next", 32'(ok), 32'd1);
    wait_valid(30);
    check("t4_out_gcd", out_gcd, 16'd4);
    step();
    wait_drain(50);
    check("t4_delivered", 32'(n_delivered - d0), 32'd1);

    // Random traffic with random consumer back-pressure.
    rand_ready = 1'b1;
    d0 = n_delivered;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 17 == 0) ra = 16'd0;
      if (i % 23 == 0) rb = 16'd0;
      if (i % 5 == 0)  rb = ra;
      if ($urandom_range(0, 3) == 0) step();
      push_retry(ra, rb);
    end
    wait_drain(5000);
    check("t5_delivered", 32'(n_delivered - d0), 32'd200);
    rand_ready = 1'b0;
    out_ready  = 1'b1;

`ifdef GCD_JOB_COUNT_EN
    // Job counter: counts handshakes from reset, saturates at all ones.
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_cnt_rst", job_cnt, 16'd0);
    step();
    push_pair(16'd6, 16'd4, ok);
    push_pair(16'd15, 16'd10, ok);
    push_pair(16'd49, 16'd14, ok);
    wait_drain(200);
    @(negedge clk);
    check("t6_cnt_three", job_cnt, 16'd3);
    force dut.job_cnt = 16'hFFFF;
    step();
    release dut.job_cnt;
    push_pair(16'd8, 16'd12, ok);
    wait_drain(100);
    @(negedge clk);
    check("t6_cnt_saturate", job_cnt, 16'hFFFF);
`endif

    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
